// File: rtl/tick_counter_pkg.sv
// Shared definitions for the two-digit tick counter: FSM state encodings and
// default parameter values.
package tick_counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    localparam int DEF_CLK_HZ     = 50_000_000;
    localparam int DEF_TICK_HZ    = 1;
    localparam int DEF_DEB_CYCLES = 500_000;
    localparam int DEF_MAX        = 99;

endpackage

// File: rtl/tick_counter_99_btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stable-level debouncer and
// rising-edge detector producing a single-cycle press pulse.
module btn_debounce
    import tick_counter_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

    logic [1:0]    sync_r;
    logic          level_r;
    logic          level_d_r;
    logic [CW-1:0] stable_cnt_r;

    // Synchronize, then accept a new level only after it has held DEB_CYCLES samples
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r       <= 2'b00;
            level_r      <= 1'b0;
            level_d_r    <= 1'b0;
            stable_cnt_r <= '0;
        end else begin
            sync_r    <= {sync_r[0], btn_raw};
            level_d_r <= level_r;
            if (sync_r[1] == level_r) begin
                stable_cnt_r <= '0;
            end else if (stable_cnt_r == CW'(DEB_CYCLES - 1)) begin
                level_r      <= sync_r[1];
                stable_cnt_r <= '0;
            end else begin
                stable_cnt_r <= stable_cnt_r + CW'(1);
            end
        end
    end

    assign btn_level = level_r;
    assign btn_press = level_r & ~level_d_r;

endmodule

// File: rtl/tick_counter_99.sv
// Up/down 0..MAX counter advanced once per prescaled tick, driven by
// debounced start/pause and clear buttons; feeds the two-digit BCD display.
module tick_counter_99
    import tick_counter_pkg::*;
#(
    parameter int CLK_HZ     = DEF_CLK_HZ,
    parameter int TICK_HZ    = DEF_TICK_HZ,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int MAX        = DEF_MAX,
    parameter int W          = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         btn_start,
    input  logic         btn_clr,
    input  logic         dir,
    output logic [W-1:0] count_out,
    output logic         running,
    output logic         wrap_pulse
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [1:0]    dir_sync_r;
    state_t        state_r;
    state_t        state_nx_s;
    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_nx_s;
    logic [W-1:0]  count_r;
    logic [W-1:0]  count_nx_s;
    logic          wrap_r;
    logic          wrap_nx_s;
    logic          running_r;
    logic          tick_s;
    logic          start_p_s;
    logic          clr_p_s;
    logic          unused_start_level_s;
    logic          unused_clr_level_s;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_start),
        .btn_level (unused_start_level_s),
        .btn_press (start_p_s)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_clr),
        .btn_level (unused_clr_level_s),
        .btn_press (clr_p_s)
    );

    assign tick_s = (state_r == RUN) && (presc_r == PW'(DIV - 1));

    // Next state, prescaler and count; a clear press overrides start and tick
    always_comb begin
        state_nx_s = state_r;
        presc_nx_s = presc_r;
        count_nx_s = count_r;
        wrap_nx_s  = 1'b0;

        if (clr_p_s) begin
            state_nx_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_nx_s = start_p_s ? RUN : IDLE;
                RUN:     state_nx_s = start_p_s ? PAUSE : RUN;
                PAUSE:   state_nx_s = start_p_s ? RUN : PAUSE;
                default: state_nx_s = IDLE;
            endcase
        end

        if (clr_p_s || (state_r == IDLE)) begin
            presc_nx_s = '0;
        end else if (state_r == RUN) begin
            presc_nx_s = tick_s ? '0 : (presc_r + PW'(1));
        end else begin
            presc_nx_s = presc_r;
        end

        if (clr_p_s || (state_r == IDLE)) begin
            count_nx_s = '0;
        end else if (tick_s) begin
            if (dir_sync_r[1]) begin
                if (count_r == W'(MAX)) begin
                    count_nx_s = '0;
                    wrap_nx_s  = 1'b1;
                end else begin
                    count_nx_s = count_r + W'(1);
                end
            end else begin
                if (count_r == W'(0)) begin
                    count_nx_s = W'(MAX);
                    wrap_nx_s  = 1'b1;
                end else begin
                    count_nx_s = count_r - W'(1);
                end
            end
        end else begin
            count_nx_s = count_r;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_sync_r <= 2'b00;
            state_r    <= IDLE;
            presc_r    <= '0;
            count_r    <= '0;
            wrap_r     <= 1'b0;
            running_r  <= 1'b0;
        end else begin
            dir_sync_r <= {dir_sync_r[0], dir};
            state_r    <= state_nx_s;
            presc_r    <= presc_nx_s;
            count_r    <= count_nx_s;
            wrap_r     <= wrap_nx_s;
            running_r  <= (state_nx_s == RUN);
        end
    end

    assign count_out  = count_r;
    assign running    = running_r;
    assign wrap_pulse = wrap_r;

endmodule

// File: tb/tb_tick_counter_99.sv
// Directed bench for tick_counter_99 with DIV=10, DEB_CYCLES=3, MAX=99:
// a timed vector table for counting/wrap/pause/clear plus hand-written
// glitch, bounce and mid-count reset sequences.
module tb_tick_counter_99;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_clr = 1'b0;
    logic       dir = 1'b0;
    logic [7:0] count_out;
    logic       running;
    logic       wrap_pulse;

    int cyc = 0;
    int base = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int         off;
        logic       bs;
        logic       bc;
        logic       dr;
        logic [7:0] cnt;
        logic       run;
        logic       wrap;
    } vec_t;

    vec_t vecs[$];

    tick_counter_99 #(
        .CLK_HZ     (10),
        .TICK_HZ    (1),
        .DEB_CYCLES (3),
        .MAX        (99),
        .W          (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_start  (btn_start),
        .btn_clr    (btn_clr),
        .dir        (dir),
        .count_out  (count_out),
        .running    (running),
        .wrap_pulse (wrap_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic wait_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at offset %0d: got %0d, expected %0d", name, cyc - base, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int cnt, input int run, input int wrap);
        check({tag, ".count"}, int'(count_out), cnt);
        check({tag, ".running"}, int'(running), run);
        check({tag, ".wrap"}, int'(wrap_pulse), wrap);
    endtask

    initial begin
        // offset, btn_start, btn_clr, dir (driven after the compare), then expected count/running/wrap
        // Start press at 0: pulse in cycle 5, RUN from 6, ticks land on 16, 26, ...
        vecs.push_back('{0,    1'b1, 1'b0, 1'b1, 8'd0,  1'b0, 1'b0});
        vecs.push_back('{5,    1'b1, 1'b0, 1'b1, 8'd0,  1'b0, 1'b0});
        vecs.push_back('{6,    1'b1, 1'b0, 1'b1, 8'd0,  1'b1, 1'b0});
        vecs.push_back('{10,   1'b0, 1'b0, 1'b1, 8'd0,  1'b1, 1'b0});
        vecs.push_back('{15,   1'b0, 1'b0, 1'b1, 8'd0,  1'b1, 1'b0});
        vecs.push_back('{16,   1'b0, 1'b0, 1'b1, 8'd1,  1'b1, 1'b0});
        vecs.push_back('{26,   1'b0, 1'b0, 1'b1, 8'd2,  1'b1, 1'b0});
        vecs.push_back('{36,   1'b0, 1'b0, 1'b1, 8'd3,  1'b1, 1'b0});
        // Up through 98, 99 and the wrap to 0
        vecs.push_back('{986,  1'b0, 1'b0, 1'b1, 8'd98, 1'b1, 1'b0});
        vecs.push_back('{996,  1'b0, 1'b0, 1'b1, 8'd99, 1'b1, 1'b0});
        vecs.push_back('{1005, 1'b0, 1'b0, 1'b1, 8'd99, 1'b1, 1'b0});
        vecs.push_back('{1006, 1'b0, 1'b0, 1'b1, 8'd0,  1'b1, 1'b1});
        vecs.push_back('{1007, 1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0});
        // Down from 0 wraps to 99, then 98
        vecs.push_back('{1015, 1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0});
        vecs.push_back('{1016, 1'b0, 1'b0, 1'b0, 8'd99, 1'b1, 1'b1});
        vecs.push_back('{1017, 1'b0, 1'b0, 1'b0, 8'd99, 1'b1, 1'b0});
        // Pause so the prescaler freezes at 4, resume 50 cycles later
        vecs.push_back('{1024, 1'b1, 1'b0, 1'b0, 8'd99, 1'b1, 1'b0});
        vecs.push_back('{1026, 1'b1, 1'b0, 1'b0, 8'd98, 1'b1, 1'b0});
        vecs.push_back('{1029, 1'b1, 1'b0, 1'b0, 8'd98, 1'b1, 1'b0});
        vecs.push_back('{1030, 1'b1, 1'b0, 1'b0, 8'd98, 1'b0, 1'b0});
        vecs.push_back('{1034, 1'b0, 1'b0, 1'b0, 8'd98, 1'b0, 1'b0});
        vecs.push_back('{1060, 1'b0, 1'b0, 1'b0, 8'd98, 1'b0, 1'b0});
        vecs.push_back('{1080, 1'b1, 1'b0, 1'b0, 8'd98, 1'b0, 1'b0});
        vecs.push_back('{1085, 1'b1, 1'b0, 1'b0, 8'd98, 1'b0, 1'b0});
        vecs.push_back('{1086, 1'b1, 1'b0, 1'b0, 8'd98, 1'b1, 1'b0});
        vecs.push_back('{1090, 1'b0, 1'b0, 1'b0, 8'd98, 1'b1, 1'b0});
        vecs.push_back('{1091, 1'b0, 1'b0, 1'b0, 8'd98, 1'b1, 1'b0});
        vecs.push_back('{1092, 1'b0, 1'b0, 1'b0, 8'd97, 1'b1, 1'b0});
        // Start+clear together at 37, landing on the same cycle as a tick
        vecs.push_back('{1692, 1'b0, 1'b0, 1'b0, 8'd37, 1'b1, 1'b0});
        vecs.push_back('{1696, 1'b1, 1'b1, 1'b0, 8'd37, 1'b1, 1'b0});
        vecs.push_back('{1701, 1'b1, 1'b1, 1'b0, 8'd37, 1'b1, 1'b0});
        vecs.push_back('{1702, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0});
        vecs.push_back('{1703, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0});
        vecs.push_back('{1706, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0});
        vecs.push_back('{1720, 1'b0, 1'b0, 1'b1, 8'd0,  1'b0, 1'b0});

        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 0);
        rst = 1'b0;
        base = cyc;

        foreach (vecs[i]) begin
            wait_to(base + vecs[i].off);
            check_all($sformatf("vec%0d", i), int'(vecs[i].cnt), int'(vecs[i].run), int'(vecs[i].wrap));
            btn_start = vecs[i].bs;
            btn_clr   = vecs[i].bc;
            dir       = vecs[i].dr;
        end

        // Two-cycle glitch must not start the counter
        wait_to(base + 1730);
        btn_start = 1'b1;
        wait_to(base + 1732);
        btn_start = 1'b0;
        wait_to(base + 1745);
        check_all("glitch", 0, 0, 0);

        // Bounce 1/0/1 then hold: exactly one press, RUN from offset 1758
        wait_to(base + 1750);
        btn_start = 1'b1;
        wait_to(base + 1751);
        btn_start = 1'b0;
        wait_to(base + 1752);
        btn_start = 1'b1;
        wait_to(base + 1757);
        check("bounce.before", int'(running), 0);
        wait_to(base + 1758);
        check("bounce.run", int'(running), 1);
        wait_to(base + 1762);
        btn_start = 1'b0;
        wait_to(base + 1768);
        check("bounce.first_tick", int'(count_out), 1);
        wait_to(base + 1790);
        check_all("bounce.single_press", 3, 1, 0);

        // Reset mid-count at 55
        wait_to(base + 2308);
        check_all("pre_reset", 55, 1, 0);
        rst = 1'b1;
        wait_to(base + 2309);
        check_all("mid_reset", 0, 0, 0);
        rst = 1'b0;
        wait_to(base + 2330);
        check_all("post_reset_idle", 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
